// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data-memory controller.
// Consumers: data_mem_ctrl, dmem_ram, data_mem_ctrl_if.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_WAIT,
        RESP_WAIT
    } dmem_state_e;

    function automatic int addr_idx_width(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

    function automatic int cnt_width(input int max_count);
        return (max_count > 0) ? $clog2(max_count + 1) : 1;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// req/gnt/r_valid data port between the control unit (master) and data memory (slave).
// DMEM_ERR_EN adds the data_err response flag.
interface data_mem_ctrl_if;
    import dmem_pkg::*;

    logic              data_req;
    logic              data_write_enable;
    logic [BE_W-1:0]   data_be;
    logic [WORD_W-1:0] data_addr;
    logic [WORD_W-1:0] data_wdata;
    logic              data_gnt;
    logic              data_r_valid;
    logic [WORD_W-1:0] data_rdata;
`ifdef DMEM_ERR_EN
    logic              data_err;
`endif

    modport master (
        output data_req, data_write_enable, data_be, data_addr, data_wdata,
        input  data_gnt, data_r_valid, data_rdata
`ifdef DMEM_ERR_EN
        , input data_err
`endif
    );

    modport slave (
        input  data_req, data_write_enable, data_be, data_addr, data_wdata,
        output data_gnt, data_r_valid, data_rdata
`ifdef DMEM_ERR_EN
        , output data_err
`endif
    );

endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are never reset.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = addr_idx_width(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < BE_W; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory slave: req/gnt/r_valid handshake, one outstanding access, configurable latencies.
// DMEM_ERR_EN enables misaligned/out-of-range detection and the data_err response flag.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          GNT_LATENCY = 0,
    parameter int          RD_LATENCY  = 1
) (
    input  logic           CLK,
    input  logic           RES,
    data_mem_ctrl_if.slave bus
);

    localparam int AW  = addr_idx_width(DEPTH_WORDS);
    localparam int GCW = cnt_width(GNT_LATENCY);
    localparam int LCW = cnt_width(RD_LATENCY);

    dmem_state_e       state, state_n;
    logic [GCW-1:0]    gnt_cnt;
    logic [LCW-1:0]    lat_cnt;
    logic              gnt;
    logic              fire;
    logic              acc_err;
    logic              resp_zero;
    logic [WORD_W-1:0] offset;
    logic [WORD_W-1:0] ram_q;
    logic [AW-1:0]     idx;
    logic              unused_addr_bits;

    assign offset           = bus.data_addr - BASE_ADDR;
    assign idx              = offset[AW+1:2];
    assign unused_addr_bits = ^offset;

`ifdef DMEM_ERR_EN
    logic resp_err;
    assign acc_err = (bus.data_addr[1:0] != 2'b00) || (offset[WORD_W-1:AW+2] != '0);
`else
    assign acc_err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        gnt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.data_req) begin
                    if (GNT_LATENCY == 0) begin
                        gnt     = 1'b1;
                        state_n = RESP_WAIT;
                    end else begin
                        state_n = GRANT_WAIT;
                    end
                end
            end
            GRANT_WAIT: begin
                if (!bus.data_req) begin
                    state_n = IDLE;
                end else if (gnt_cnt == '0) begin
                    gnt     = 1'b1;
                    state_n = RESP_WAIT;
                end
            end
            RESP_WAIT: begin
                if (lat_cnt == '0) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.data_gnt = gnt;

    // The pulse is registered, so it is launched one edge before the last RESP_WAIT cycle.
    assign fire = (gnt && (RD_LATENCY == 1)) || ((state == RESP_WAIT) && (lat_cnt == LCW'(1)));

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state            <= IDLE;
            gnt_cnt          <= '0;
            lat_cnt          <= '0;
            resp_zero        <= 1'b1;
            bus.data_r_valid <= 1'b0;
        end else begin
            state            <= state_n;
            bus.data_r_valid <= fire;
            if ((GNT_LATENCY > 0) && (state == IDLE) && bus.data_req) begin
                gnt_cnt <= GCW'(GNT_LATENCY - 1);
            end else if ((state == GRANT_WAIT) && bus.data_req && (gnt_cnt != '0)) begin
                gnt_cnt <= gnt_cnt - 1'b1;
            end
            if (gnt) begin
                lat_cnt   <= LCW'(RD_LATENCY - 1);
                resp_zero <= bus.data_write_enable | acc_err;
            end else if ((state == RESP_WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

`ifdef DMEM_ERR_EN
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            resp_err     <= 1'b0;
            bus.data_err <= 1'b0;
        end else begin
            if (gnt) resp_err <= acc_err;
            bus.data_err <= fire & ((RD_LATENCY == 1) ? acc_err : resp_err);
        end
    end
`endif

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (CLK),
        .en    (gnt),
        .we    (bus.data_write_enable & ~acc_err),
        .be    (bus.data_be),
        .addr  (idx),
        .wdata (bus.data_wdata),
        .rdata (ram_q)
    );

    // With single-cycle latency the RAM read register already is the response register;
    // longer latencies copy it at the pulse so rdata only changes when r_valid fires.
    if (RD_LATENCY == 1) begin : g_rd_direct
        assign bus.data_rdata = resp_zero ? '0 : ram_q;
    end else begin : g_rd_hold
        logic [WORD_W-1:0] rdata_q;
        always_ff @(posedge CLK or posedge RES) begin
            if (RES)       rdata_q <= '0;
            else if (fire) rdata_q <= resp_zero ? '0 : ram_q;
        end
        assign bus.data_rdata = rdata_q;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised self-checking bench for data_mem_ctrl: default-latency instance and a GNT=2/RD=3 instance.
// Error-response checks are compiled in when DMEM_ERR_EN is defined.
module tb_data_mem_ctrl;
    import dmem_pkg::*;

    localparam int          DEPTH_A = 1024;
    localparam int          DEPTH_B = 16;
    localparam logic [31:0] BASE_A  = 32'h0000_0000;
    localparam logic [31:0] BASE_B  = 32'h0000_0100;
`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        res;
    logic        req [2];
    logic        we [2];
    logic [3:0]  be [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        gnt [2];
    logic        rv [2];
    logic        err [2];
    logic [31:0] rdata [2];

    logic [31:0] mdl [2][DEPTH_A];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl_if bus_a ();
    data_mem_ctrl_if bus_b ();

    assign bus_a.data_req          = req[0];
    assign bus_a.data_write_enable = we[0];
    assign bus_a.data_be           = be[0];
    assign bus_a.data_addr         = addr[0];
    assign bus_a.data_wdata        = wdata[0];
    assign gnt[0]                  = bus_a.data_gnt;
    assign rv[0]                   = bus_a.data_r_valid;
    assign rdata[0]                = bus_a.data_rdata;
    assign bus_b.data_req          = req[1];
    assign bus_b.data_write_enable = we[1];
    assign bus_b.data_be           = be[1];
    assign bus_b.data_addr         = addr[1];
    assign bus_b.data_wdata        = wdata[1];
    assign gnt[1]                  = bus_b.data_gnt;
    assign rv[1]                   = bus_b.data_r_valid;
    assign rdata[1]                = bus_b.data_rdata;
`ifdef DMEM_ERR_EN
    assign err[0] = bus_a.data_err;
    assign err[1] = bus_b.data_err;
`else
    assign err[0] = 1'b0;
    assign err[1] = 1'b0;
`endif

    data_mem_ctrl #(
        .DEPTH_WORDS (DEPTH_A),
        .BASE_ADDR   (BASE_A),
        .GNT_LATENCY (0),
        .RD_LATENCY  (1)
    ) dut_a (
        .CLK (clk),
        .RES (res),
        .bus (bus_a)
    );

    data_mem_ctrl #(
        .DEPTH_WORDS (DEPTH_B),
        .BASE_ADDR   (BASE_B),
        .GNT_LATENCY (2),
        .RD_LATENCY  (3)
    ) dut_b (
        .CLK (clk),
        .RES (res),
        .bus (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int gl(input int s);
        return (s == 0) ? 0 : 2;
    endfunction

    function automatic int rl(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] base(input int s);
        return (s == 0) ? BASE_A : BASE_B;
    endfunction

    function automatic int depth(input int s);
        return (s == 0) ? DEPTH_A : DEPTH_B;
    endfunction

    function automatic int widx(input int s, input logic [31:0] a);
        logic [31:0] off;
        off = a - base(s);
        return int'(off >> 2) % depth(s);
    endfunction

    function automatic bit model_err(input int s, input logic [31:0] a);
        longint off;
        bit     bad;
        off = longint'(a) - longint'(base(s));
        bad = (a[1:0] != 2'b00) || (off < 0) || (off >= 4 * longint'(depth(s)));
        return ERR_EN && bad;
    endfunction

    // One complete transaction: latency, data, pulse width and hold-after-pulse are all checked.
    task automatic access(input int s, input bit w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold, input string tag,
                          output logic [31:0] got);
        int          n;
        int          m;
        int          idx;
        bit          e;
        bit          seen;
        bit          quiet;
        logic [31:0] exp_rd;
        e      = model_err(s, a);
        idx    = widx(s, a);
        exp_rd = (w || e) ? 32'h0 : mdl[s][idx];
        got    = 32'hx;
        @(posedge clk); #1;
        req[s] = 1'b1; we[s] = w; be[s] = b; addr[s] = a; wdata[s] = wd;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk); n++;
            if (gnt[s]) seen = 1'b1;
            else @(posedge clk);
        end
        check({tag, " gnt_cycle"}, 32'(n), 32'(gl(s) + 1));
        if (!seen) begin
            req[s] = 1'b0;
            return;
        end
        if (w && !e) begin
            for (int i = 0; i < 4; i++) if (b[i]) mdl[s][idx][8*i +: 8] = wd[8*i +: 8];
        end
        @(posedge clk); #1;
        if (!hold) begin
            req[s] = 1'b0; addr[s] = $urandom; wdata[s] = $urandom; be[s] = 4'($urandom);
        end
        m = 0; seen = 1'b0; quiet = 1'b1;
        while (!seen && m < 40) begin
            @(negedge clk); m++;
            if (gnt[s]) quiet = 1'b0;
            if (rv[s]) seen = 1'b1;
        end
        req[s] = 1'b0;
        got = rdata[s];
        check({tag, " rv_latency"}, 32'(m), 32'(rl(s)));
        check({tag, " rdata"}, rdata[s], exp_rd);
`ifdef DMEM_ERR_EN
        check({tag, " err"}, 32'(err[s]), 32'(e));
`endif
        if (hold) check({tag, " no_gnt_in_resp"}, 32'(quiet), 32'h1);
        @(negedge clk);
        check({tag, " rv_pulse"}, 32'(rv[s]), 32'h0);
        check({tag, " rdata_hold"}, rdata[s], exp_rd);
    endtask

    task automatic abort_req(input int ncyc, input logic [31:0] a, input logic [31:0] wd);
        bit quiet;
        quiet = 1'b1;
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = a; wdata[1] = wd;
        repeat (ncyc) begin
            @(negedge clk);
            if (gnt[1]) quiet = 1'b0;
        end
        @(posedge clk); #1;
        req[1] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (gnt[1] || rv[1]) quiet = 1'b0;
        end
        check("abort_quiet", 32'(quiet), 32'h1);
    endtask

    // Grant an access on the slow instance, then reset during its RESP_WAIT.
    task automatic reset_in_resp(input bit w, input logic [31:0] a, input logic [31:0] wd);
        int n;
        bit seen;
        bit quiet;
        n = 0; seen = 1'b0; quiet = 1'b1;
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = w; be[1] = 4'hF; addr[1] = a; wdata[1] = wd;
        while (!seen && n < 40) begin
            @(negedge clk); n++;
            if (gnt[1]) seen = 1'b1;
            else @(posedge clk);
        end
        check("rst_gnt_seen", 32'(seen), 32'h1);
        if (seen && w && !model_err(1, a)) mdl[1][widx(1, a)] = wd;
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        res = 1'b1;
        #1;
        check("rst_mid rv", 32'(rv[1]), 32'h0);
        check("rst_mid rdata", rdata[1], 32'h0);
        @(negedge clk);
        res = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rv[1]) quiet = 1'b0;
        end
        check("rst_no_rv_after", 32'(quiet), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int          s;
        int          idx;
        bit          w;
        bit          hold;
        logic [3:0]  b;
        logic [31:0] a;
        res = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset gnt", 32'(gnt[i]), 32'h0);
            check("reset rv", 32'(rv[i]), 32'h0);
            check("reset rdata", rdata[i], 32'h0);
`ifdef DMEM_ERR_EN
            check("reset err", 32'(err[i]), 32'h0);
`endif
        end
        res = 1'b0;

        for (int si = 0; si < 2; si++) begin
            for (int i = 0; i < 16; i++) begin
                access(si, 1'b1, 4'hF, base(si) + 32'(4 * i), $urandom, 1'b0, "init", got);
            end
        end

        access(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, "w10", got);
        access(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, "r10", got);
        check("r10 const", got, 32'hDEADBEEF);
        access(0, 1'b1, 4'hF, 32'h14, 32'h11223344, 1'b0, "w14", got);
        access(0, 1'b1, 4'h1, 32'h14, 32'h000000AA, 1'b0, "w14b", got);
        access(0, 1'b0, 4'hF, 32'h14, 32'h0, 1'b1, "r14", got);
        check("r14 const", got, 32'h112233AA);

        access(0, 1'b0, 4'hF, BASE_A + 32'(4 * DEPTH_A), 32'h0, 1'b0, "oor_read", got);
        check("oor_read const", got, ERR_EN ? 32'h0 : mdl[0][0]);
        access(0, 1'b1, 4'hF, 32'h2, 32'hCAFEF00D, 1'b0, "mis_write", got);
        access(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, "word0", got);

        access(1, 1'b1, 4'hF, BASE_B + 32'h1C, 32'h5A5A_0001, 1'b0, "b_w7", got);
        abort_req(1, BASE_B + 32'h1C, 32'hFFFF_FFFF);
        abort_req(2, BASE_B + 32'h1C, 32'hEEEE_EEEE);
        access(1, 1'b0, 4'hF, BASE_B + 32'h1C, 32'h0, 1'b1, "b_r7", got);
        check("b_r7 const", got, 32'h5A5A_0001);

        access(1, 1'b1, 4'hF, BASE_B + 32'h0C, 32'h0BAD_C0DE, 1'b0, "b_w3", got);
        access(1, 1'b0, 4'hF, BASE_B + 32'h0C, 32'h0, 1'b0, "b_r3", got);
        reset_in_resp(1'b0, BASE_B + 32'h0C, 32'h0);
        access(1, 1'b0, 4'hF, BASE_B + 32'h0C, 32'h0, 1'b0, "b_r3_after_rst", got);
        check("b_r3 const", got, 32'h0BAD_C0DE);
        reset_in_resp(1'b1, BASE_B + 32'h14, 32'h1357_9BDF);
        access(1, 1'b0, 4'hF, BASE_B + 32'h14, 32'h0, 1'b0, "b_r5_committed", got);
        check("b_r5 const", got, 32'h1357_9BDF);

        for (int k = 0; k < 60; k++) begin
            s    = int'($urandom % 2);
            idx  = int'($urandom % 16);
            w    = 1'($urandom);
            hold = ($urandom % 4) == 0;
            b    = 4'($urandom);
            a    = base(s) + 32'(4 * idx);
            if ($urandom % 4 == 0) a = a + 32'($urandom % 4);
            if ($urandom % 8 == 0) a = a + 32'(4 * depth(s));
            access(s, w, b, a, $urandom, hold, "rand", got);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory slave sitting directly downstream of the control unit's data port: it answers `data_req` with `data_gnt`, performs the access on a word-organised on-chip RAM and returns `data_r_valid`/`data_rdata` after a configurable latency. It implements the same req/gnt/r_valid handshake the control unit drives for LW/SW, with one outstanding transaction at most. It also serves as the bench memory model for the core.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; must be a power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address mapped to word 0.
- `GNT_LATENCY`, 0: cycles of continuous `data_req` before `data_gnt`; 0 means combinational grant.
- `RD_LATENCY`, 1: cycles from the grant edge to `data_r_valid`; must be ≥1.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RES` in 1: reset, asynchronous, active-high.
- `data_req` in 1: access request, held until granted.
- `data_write_enable` in 1: 1 means write, 0 means read.
- `data_be` in 4: byte enables, bit i covers `wdata[8i+7:8i]`.
- `data_addr` in 32: byte address.
- `data_wdata` in 32: write data.
- `data_gnt` out 1: request accepted this cycle.
- `data_r_valid` out 1: one-cycle response pulse.
- `data_rdata` out 32: read data, valid with `data_r_valid`.
- `data_err` out 1: present only with `DMEM_ERR_EN`; valid with `data_r_valid`.

## Operation
- States: IDLE, GRANT_WAIT, RESP_WAIT.
- IDLE:
  - With `data_req=1` and `GNT_LATENCY=0`: `data_gnt=1` in the same cycle, and the state goes to RESP_WAIT.
  - With `GNT_LATENCY>0`: go to GRANT_WAIT and load the grant counter.
- GRANT_WAIT:
  - The counter decrements each cycle `data_req=1`.
  - At zero: `data_gnt=1` that cycle, then go to RESP_WAIT.
  - If `data_req` drops before the grant: abort, return to IDLE, no access.
- Grant edge: address, write enable, byte enables and wdata are sampled.
  - Write: RAM is updated at this edge for enabled bytes only.
  - Read: the word is read and held in the response register.
- RESP_WAIT: a latency counter runs `RD_LATENCY` cycles, then `data_r_valid=1` for exactly one cycle and the state returns to IDLE.
  - Writes also receive an `r_valid` pulse; `rdata` is 0 for writes.
- No grant is issued while in RESP_WAIT; `data_req` is ignored there.
- Word index = `(data_addr − BASE_ADDR) >> 2`, truncated modulo `DEPTH_WORDS`. `data_addr[1:0]` is ignored.
- `data_rdata` holds its last response value between pulses.

## Timing
- Reset values: `data_gnt=0`, `data_r_valid=0`, `data_rdata=0`, `data_err=0`, state IDLE, counters 0.
- RAM contents are not cleared by reset.
- Reset mid-transaction drops any pending response: no `r_valid` after reset release. A write already granted before reset stays committed.
- Default latency (`GNT_LATENCY=0`, `RD_LATENCY=1`): req/gnt in cycle N, `r_valid` in cycle N+1.
- Total request-to-response latency = `GNT_LATENCY + RD_LATENCY` cycles.
- A read from the same word in the cycle after a write's grant returns the new data.
- `data_gnt` is combinational from `data_req` and state; all other outputs are registered.

## Configuration
- `DMEM_ERR_EN` defined:
  - Adds the `data_err` port.
  - A misaligned access (`data_addr[1:0]≠0`) or an address outside `[BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)` is granted normally but suppresses the write. The response carries `rdata=0` and `data_err=1`.
- `DMEM_ERR_EN` undefined: no `data_err` port; such addresses wrap or truncate as described in Operation.

## Structure
- Package `dmem_pkg`:
  - state enum (IDLE/GRANT_WAIT/RESP_WAIT);
  - word-width and byte-enable-width constants;
  - address-index width function.
- Sub-module `dmem_ram`: single-port synchronous RAM with per-byte write enables and a registered read. The FSM, counters and response register stay in `data_mem_ctrl`.

## Test plan
- Reset, then write `32'hDEADBEEF` to `0x10` with `be=4'hF`, then read `0x10`: gnt in the request cycle, `r_valid` one cycle later, `rdata=32'hDEADBEEF`.
- Write `32'h000000AA` with `be=4'h1` over `32'h11223344`, then read back: `32'h112233AA`.
- `GNT_LATENCY=2`, `RD_LATENCY=3`: gnt on the third req cycle, `r_valid` exactly 3 cycles after gnt. A req dropped after 1 cycle gives no gnt, no `r_valid`, and memory unchanged.
- Assert `RES` during RESP_WAIT of a read: `r_valid` never pulses, outputs are 0, and the next read of a previously written word returns the stored value.
- `DMEM_ERR_EN`: read `BASE_ADDR+4*DEPTH_WORDS` → `data_err=1`, `rdata=0`. Write to `0x2` → `data_err=1` and word 0 unchanged. Without the macro, the same out-of-range read returns the contents of word 0.
